// File: rtl/draw_puck_if.sv
// rtl/draw_puck_if.sv - VGA timing bus plus RGB passed between draw stages

interface draw_puck_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/draw_puck.sv
// rtl/draw_puck.sv - puck physics, goal/serve sequencing and disc overlay stage

module draw_puck #(
    parameter int          RADIUS       = 12,
    parameter int          X_MIN        = 47,
    parameter int          X_MAX        = 976,
    parameter int          Y_MIN        = 47,
    parameter int          Y_MAX        = 720,
    parameter int          GOAL_TOP     = 266,
    parameter int          GOAL_BOT     = 450,
    parameter int          X_CENTER     = 486,
    parameter int          Y_CENTER     = 358,
    parameter int          SERVE_FRAMES = 60,
    parameter logic [11:0] PUCK_COLOUR  = 12'h0_0_0
) (
    input  logic              clk_in,
    input  logic              rst_n,
    draw_puck_if.slave        vga_in,
    draw_puck_if.master       vga_out,
    input  logic              hit_valid,
    input  logic signed [5:0] hit_vx,
    input  logic signed [5:0] hit_vy,
    output logic [11:0]       puck_x,
    output logic [11:0]       puck_y,
    output logic              goal_left,
    output logic              goal_right,
    output logic [3:0]        score_left,
    output logic [3:0]        score_right
);

    typedef enum logic [1:0] {SERVE, PLAY, GOAL} state_t;

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [12:0] RAD   = 13'(RADIUS);
    localparam logic signed [12:0] XMIN  = 13'(X_MIN);
    localparam logic signed [12:0] XMAX  = 13'(X_MAX);
    localparam logic signed [12:0] YMIN  = 13'(Y_MIN);
    localparam logic signed [12:0] YMAX  = 13'(Y_MAX);
    localparam logic signed [12:0] GTOP  = 13'(GOAL_TOP);
    localparam logic signed [12:0] GBOT  = 13'(GOAL_BOT);
    localparam logic [11:0]        XC    = 12'(X_CENTER);
    localparam logic [11:0]        YC    = 12'(Y_CENTER);
    localparam logic [11:0]        X_LO  = 12'(X_MIN + RADIUS);
    localparam logic [11:0]        X_HI  = 12'(X_MAX - RADIUS);
    localparam logic [11:0]        Y_LO  = 12'(Y_MIN + RADIUS);
    localparam logic [11:0]        Y_HI  = 12'(Y_MAX - RADIUS);
    localparam logic [CW-1:0]      S_END = CW'(SERVE_FRAMES - 1);
    localparam logic [25:0]        R_SQ  = 26'(RADIUS * RADIUS);

    state_t            state, state_nxt;
    logic              vblnk_prev;
    logic              tick;
    logic [11:0]       x, y, x_nxt, y_nxt;
    logic signed [5:0] vx, vy, vx_nxt, vy_nxt;
    logic signed [5:0] vx_use, vy_use;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              pend_valid, pend_valid_nxt;
    logic signed [5:0] pend_vx, pend_vy, pend_vx_nxt, pend_vy_nxt;
    logic [3:0]        score_l, score_r, score_l_nxt, score_r_nxt;
    logic              goal_l_nxt, goal_r_nxt;
    logic signed [12:0] nx, ny;
    logic              scored;
    logic [11:0]       draw_x, draw_y;

    // Render pipeline registers (stage 1)
    logic signed [12:0] dx, dy;
    logic [11:0]        hcount_d1, vcount_d1, rgb_d1;
    logic               hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
    logic signed [25:0] dx_w, dy_w;
    logic [25:0]        dist_sq;
    logic               in_disc;

    // -32 has no positive 6-bit counterpart, so it reflects to +31
    function automatic logic signed [5:0] negate(input logic signed [5:0] v);
        return (v == 6'b100000) ? 6'sd31 : 6'(-v);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'd9) ? 4'd9 : s + 4'd1;
    endfunction

    assign tick        = vga_in.vblnk & ~vblnk_prev;
    assign puck_x      = x;
    assign puck_y      = y;
    assign score_left  = score_l;
    assign score_right = score_r;

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= SERVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-frame physics: pending hits, move, bounce, goal, serve
    always_comb begin
        state_nxt      = state;
        x_nxt          = x;
        y_nxt          = y;
        vx_nxt         = vx;
        vy_nxt         = vy;
        cnt_nxt        = cnt;
        pend_valid_nxt = pend_valid;
        pend_vx_nxt    = pend_vx;
        pend_vy_nxt    = pend_vy;
        score_l_nxt    = score_l;
        score_r_nxt    = score_r;
        goal_l_nxt     = 1'b0;
        goal_r_nxt     = 1'b0;
        vx_use         = vx;
        vy_use         = vy;
        nx             = '0;
        ny             = '0;
        scored         = 1'b0;

        if (state == SERVE) begin
            pend_valid_nxt = 1'b0;
        end else if (hit_valid) begin
            pend_valid_nxt = 1'b1;
            pend_vx_nxt    = hit_vx;
            pend_vy_nxt    = hit_vy;
        end

        if (tick) begin
            pend_valid_nxt = 1'b0;
            unique case (state)
                SERVE: begin
                    x_nxt  = XC;
                    y_nxt  = YC;
                    vx_nxt = '0;
                    vy_nxt = '0;
                    if (cnt == S_END) begin
                        state_nxt = PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                PLAY: begin
                    // A hit on the tick cycle beats an older pending one
                    if (hit_valid) begin
                        vx_use = hit_vx;
                        vy_use = hit_vy;
                    end else if (pend_valid) begin
                        vx_use = pend_vx;
                        vy_use = pend_vy;
                    end
                    vx_nxt = vx_use;
                    vy_nxt = vy_use;
                    nx = {1'b0, x} + {{7{vx_use[5]}}, vx_use};
                    ny = {1'b0, y} + {{7{vy_use[5]}}, vy_use};

                    if (nx - RAD < XMIN) begin
                        if (ny >= GTOP && ny <= GBOT) begin
                            scored      = 1'b1;
                            goal_r_nxt  = 1'b1;
                            score_r_nxt = sat_inc(score_r);
                            state_nxt   = GOAL;
                        end else begin
                            x_nxt  = X_LO;
                            vx_nxt = negate(vx_use);
                        end
                    end else if (nx + RAD > XMAX) begin
                        if (ny >= GTOP && ny <= GBOT) begin
                            scored      = 1'b1;
                            goal_l_nxt  = 1'b1;
                            score_l_nxt = sat_inc(score_l);
                            state_nxt   = GOAL;
                        end else begin
                            x_nxt  = X_HI;
                            vx_nxt = negate(vx_use);
                        end
                    end else begin
                        x_nxt = nx[11:0];
                    end

                    // On a goal the puck stays at its last legal position
                    if (!scored) begin
                        if (ny - RAD < YMIN) begin
                            y_nxt  = Y_LO;
                            vy_nxt = negate(vy_use);
                        end else if (ny + RAD > YMAX) begin
                            y_nxt  = Y_HI;
                            vy_nxt = negate(vy_use);
                        end else begin
                            y_nxt = ny[11:0];
                        end
                    end
                end
                GOAL: begin
                    state_nxt = SERVE;
                    x_nxt     = XC;
                    y_nxt     = YC;
                    vx_nxt    = '0;
                    vy_nxt    = '0;
                    cnt_nxt   = '0;
                end
                default: begin
                    state_nxt = SERVE;
                end
            endcase
        end
    end

    // Puck state registers; draw position latched per frame to avoid tearing
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            x          <= XC;
            y          <= YC;
            vx         <= '0;
            vy         <= '0;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_vx    <= '0;
            pend_vy    <= '0;
            score_l    <= '0;
            score_r    <= '0;
            goal_left  <= 1'b0;
            goal_right <= 1'b0;
            draw_x     <= XC;
            draw_y     <= YC;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            x          <= x_nxt;
            y          <= y_nxt;
            vx         <= vx_nxt;
            vy         <= vy_nxt;
            cnt        <= cnt_nxt;
            pend_valid <= pend_valid_nxt;
            pend_vx    <= pend_vx_nxt;
            pend_vy    <= pend_vy_nxt;
            score_l    <= score_l_nxt;
            score_r    <= score_r_nxt;
            goal_left  <= goal_l_nxt;
            goal_right <= goal_r_nxt;
            if (tick) begin
                draw_x <= x;
                draw_y <= y;
            end
        end
    end

    // Squared distance is carried wide enough that far-off pixels never wrap into the disc
    always_comb begin
        dx_w    = 26'(dx);
        dy_w    = 26'(dy);
        dist_sq = 26'(dx_w * dx_w + dy_w * dy_w);
        in_disc = (dist_sq <= R_SQ) && !hblnk_d1 && !vblnk_d1;
    end

    // Two-stage render pipeline: offsets first, then disc test and composite
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dx             <= '0;
            dy             <= '0;
            hcount_d1      <= '0;
            vcount_d1      <= '0;
            hsync_d1       <= 1'b0;
            vsync_d1       <= 1'b0;
            hblnk_d1       <= 1'b0;
            vblnk_d1       <= 1'b0;
            rgb_d1         <= '0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            dx             <= {1'b0, vga_in.hcount} - {1'b0, draw_x};
            dy             <= {1'b0, vga_in.vcount} - {1'b0, draw_y};
            hcount_d1      <= vga_in.hcount;
            vcount_d1      <= vga_in.vcount;
            hsync_d1       <= vga_in.hsync;
            vsync_d1       <= vga_in.vsync;
            hblnk_d1       <= vga_in.hblnk;
            vblnk_d1       <= vga_in.vblnk;
            rgb_d1         <= vga_in.rgb;
            vga_out.hcount <= hcount_d1;
            vga_out.vcount <= vcount_d1;
            vga_out.hsync  <= hsync_d1;
            vga_out.vsync  <= vsync_d1;
            vga_out.hblnk  <= hblnk_d1;
            vga_out.vblnk  <= vblnk_d1;
            vga_out.rgb    <= in_disc ? PUCK_COLOUR : rgb_d1;
        end
    end

endmodule

// File: tb/tb_draw_puck.sv
// tb/tb_draw_puck.sv - directed and random checks of draw_puck against a frame-level model

module tb_draw_puck;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic              hit_valid;
    logic signed [5:0] hit_vx, hit_vy;
    logic [11:0]       puck_x, puck_y;
    logic              goal_left, goal_right;
    logic [3:0]        score_left, score_right;

    draw_puck_if vin();
    draw_puck_if vout();

    draw_puck dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .vga_in      (vin),
        .vga_out     (vout),
        .hit_valid   (hit_valid),
        .hit_vx      (hit_vx),
        .hit_vy      (hit_vy),
        .puck_x      (puck_x),
        .puck_y      (puck_y),
        .goal_left   (goal_left),
        .goal_right  (goal_right),
        .score_left  (score_left),
        .score_right (score_right)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fails  = 0;

    localparam int P_SERVE = 0, P_PLAY = 1, P_GOAL = 2;

    // Frame-level model of the rink
    int m_x, m_y, m_vx, m_vy, m_phase, m_wait;
    int m_pv, m_pvx, m_pvy, m_sl, m_sr, m_gl, m_gr, m_dx, m_dy;

    typedef struct {
        int rgb;
        int h;
        int v;
        int hb;
    } px_t;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int reflect(input int v);
        return (v == -32) ? 31 : -v;
    endfunction

    function automatic int rs6();
        int r;
        r = int'($urandom_range(0, 63));
        return (r >= 32) ? r - 64 : r;
    endfunction

    task automatic model_reset();
        m_x = 486; m_y = 358; m_vx = 0; m_vy = 0;
        m_phase = P_SERVE; m_wait = 60;
        m_pv = 0; m_pvx = 0; m_pvy = 0;
        m_sl = 0; m_sr = 0; m_gl = 0; m_gr = 0;
        m_dx = 486; m_dy = 358;
    endtask

    task automatic model_hit(input int hx, input int hy);
        if (m_phase != P_SERVE) begin
            m_pv = 1; m_pvx = hx; m_pvy = hy;
        end
    endtask

    task automatic model_tick(input bit hv, input int hx, input int hy);
        int nx, ny;
        m_dx = m_x; m_dy = m_y;
        m_gl = 0; m_gr = 0;
        if (m_phase == P_SERVE) begin
            m_x = 486; m_y = 358; m_vx = 0; m_vy = 0;
            m_wait--;
            if (m_wait == 0) m_phase = P_PLAY;
        end else if (m_phase == P_PLAY) begin
            if (hv) begin
                m_vx = hx; m_vy = hy;
            end else if (m_pv != 0) begin
                m_vx = m_pvx; m_vy = m_pvy;
            end
            nx = m_x + m_vx;
            ny = m_y + m_vy;
            if (nx - 12 < 47 && ny >= 266 && ny <= 450) begin
                m_gr = 1; m_sr = (m_sr + 1 > 9) ? 9 : m_sr + 1; m_phase = P_GOAL;
            end else if (nx + 12 > 976 && ny >= 266 && ny <= 450) begin
                m_gl = 1; m_sl = (m_sl + 1 > 9) ? 9 : m_sl + 1; m_phase = P_GOAL;
            end else begin
                if (nx - 12 < 47) begin
                    m_x = 59; m_vx = reflect(m_vx);
                end else if (nx + 12 > 976) begin
                    m_x = 964; m_vx = reflect(m_vx);
                end else begin
                    m_x = nx;
                end
                if (ny - 12 < 47) begin
                    m_y = 59; m_vy = reflect(m_vy);
                end else if (ny + 12 > 720) begin
                    m_y = 708; m_vy = reflect(m_vy);
                end else begin
                    m_y = ny;
                end
            end
        end else begin
            m_x = 486; m_y = 358; m_vx = 0; m_vy = 0;
            m_phase = P_SERVE; m_wait = 60;
        end
        m_pv = 0;
    endtask

    task automatic do_tick(input bit hv, input int hx, input int hy);
        @(negedge clk_in);
        vin.vblnk = 1'b1;
        hit_valid = hv;
        hit_vx    = 6'(hx);
        hit_vy    = 6'(hy);
        model_tick(hv, hx, hy);
        @(posedge clk_in); #1;
        check("tick_goal_left", goal_left, m_gl);
        check("tick_goal_right", goal_right, m_gr);
        check("tick_puck_x", puck_x, m_x);
        check("tick_puck_y", puck_y, m_y);
        check("tick_score_left", score_left, m_sl);
        check("tick_score_right", score_right, m_sr);
        @(negedge clk_in);
        vin.vblnk = 1'b0;
        hit_valid = 1'b0;
        @(posedge clk_in); #1;
        check("goal_left_one_cycle", goal_left, 0);
        check("goal_right_one_cycle", goal_right, 0);
    endtask

    task automatic do_hit(input int hx, input int hy);
        @(negedge clk_in);
        hit_valid = 1'b1;
        hit_vx    = 6'(hx);
        hit_vy    = 6'(hy);
        model_hit(hx, hy);
        @(negedge clk_in);
        hit_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0, 0, 0);
    endtask

    // Scan a window around the model draw position; outputs lag inputs by 2 cycles
    task automatic render(input int span);
        px_t q[$];
        px_t p, e;
        int  d2;
        for (int v = m_dy - span; v <= m_dy + span + 1; v++) begin
            for (int h = m_dx - span; h <= m_dx + span + 2; h++) begin
                @(negedge clk_in);
                if (q.size() == 2) begin
                    e = q.pop_front();
                    check("render_rgb", vout.rgb, e.rgb);
                    check("render_hcount", vout.hcount, e.h);
                    check("render_vcount", vout.vcount, e.v);
                    check("render_hblnk", vout.hblnk, e.hb);
                end
                p.h  = h;
                p.v  = v;
                p.hb = ($urandom_range(0, 7) == 0) ? 1 : 0;
                p.rgb = int'($urandom_range(0, 4095));
                vin.hcount = 12'(h);
                vin.vcount = 12'(v);
                vin.hblnk  = p.hb[0];
                vin.hsync  = 1'($urandom_range(0, 1));
                vin.rgb    = 12'(p.rgb);
                d2 = (h - m_dx) * (h - m_dx) + (v - m_dy) * (v - m_dy);
                if (d2 <= 144 && p.hb == 0) p.rgb = 0;
                q.push_back(p);
            end
        end
        while (q.size() != 0) begin
            @(negedge clk_in);
            e = q.pop_front();
            check("render_rgb", vout.rgb, e.rgb);
            check("render_hcount", vout.hcount, e.h);
            check("render_vcount", vout.vcount, e.v);
            check("render_hblnk", vout.hblnk, e.hb);
        end
        vin.hblnk = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rgb"}, vout.rgb, 0);
        check({tag, "_hcount"}, vout.hcount, 0);
        check({tag, "_vcount"}, vout.vcount, 0);
        check({tag, "_hsync"}, vout.hsync, 0);
        check({tag, "_vsync"}, vout.vsync, 0);
        check({tag, "_hblnk"}, vout.hblnk, 0);
        check({tag, "_vblnk"}, vout.vblnk, 0);
        check({tag, "_puck_x"}, puck_x, 486);
        check({tag, "_puck_y"}, puck_y, 358);
        check({tag, "_score_l"}, score_left, 0);
        check({tag, "_score_r"}, score_right, 0);
        check({tag, "_goal_l"}, goal_left, 0);
        check({tag, "_goal_r"}, goal_right, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        hit_valid  = 1'b0;
        hit_vx     = '0;
        hit_vy     = '0;
        vin.hcount = 12'd5;
        vin.vcount = 12'd7;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b1;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = 12'hABC;
        model_reset();

        // Reset state, then the disc at centre
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset");
        vin.vsync = 1'b0;
        rst_n = 1'b1;
        render(15);

        // Serve countdown, then a constant-velocity run
        ticks(60);
        do_hit(5, 0);
        ticks(10);
        check("run_x_536", puck_x, 536);
        check("run_y_358", puck_y, 358);
        render(15);

        // Bottom wall bounce
        do_hit(0, 9);
        ticks(38);
        check("pre_bounce_y_700", puck_y, 700);
        do_tick(1'b1, 0, 10);
        check("bounce_y_708", puck_y, 708);
        do_tick(1'b0, 0, 0);
        check("after_bounce_y_698", puck_y, 698);

        // Asynchronous reset in the middle of a line
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            vin.hcount = 12'(100 + i);
            vin.vcount = 12'd200;
            vin.hsync  = 1'b1;
            vin.vsync  = 1'b1;
            vin.rgb    = 12'hFFF;
        end
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midline_reset");
        @(negedge clk_in);
        vin.hsync = 1'b0;
        vin.vsync = 1'b0;
        rst_n = 1'b1;
        model_reset();
        render(14);
        ticks(60);

        // Goal through the left mouth
        do_hit(0, -2);
        ticks(29);
        check("approach_y_300", puck_y, 300);
        do_hit(-8, 0);
        ticks(53);
        check("approach_x_62", puck_x, 62);
        do_tick(1'b0, 0, 0);
        check("goal_score_right_1", score_right, 1);
        check("goal_frozen_x", puck_x, 62);
        do_tick(1'b0, 0, 0);
        check("serve_centre_x", puck_x, 486);
        check("serve_centre_y", puck_y, 358);
        for (int i = 0; i < 60; i++) do_tick(1'b1, 5, 5);
        check("serve_held_x", puck_x, 486);
        do_tick(1'b1, 1, 0);
        check("serve_release_x", puck_x, 487);

        // Left wall outside the mouth bounces
        do_tick(1'b1, -1, 0);
        do_hit(0, -2);
        ticks(79);
        check("wall_approach_y_200", puck_y, 200);
        do_hit(-8, 0);
        ticks(53);
        check("wall_approach_x_62", puck_x, 62);
        do_tick(1'b0, 0, 0);
        check("wall_bounce_x_59", puck_x, 59);
        check("wall_no_goal_score", score_right, 1);
        do_tick(1'b0, 0, 0);
        check("wall_vx_plus8_x_67", puck_x, 67);

        // Hit coincident with the tick is used for that tick
        do_tick(1'b1, -3, 0);
        check("same_cycle_hit_x_64", puck_x, 64);
        render(14);

        // Random play against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) do_hit(rs6(), rs6());
            if ($urandom_range(0, 5) == 0) do_hit(rs6(), rs6());
            if ($urandom_range(0, 4) == 0) do_tick(1'b1, rs6(), rs6());
            else do_tick(1'b0, 0, 0);
        end
        render(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
